// File: rtl/bus_arb_4_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_4_pkg
// Shared constants for the 4-requester bus arbiter:
//   - arb_state_e : arbiter FSM state encodings (IDLE=0, OWN=1, TURN=2)
//   - MAX_HOLD_DEFAULT : default maximum hold time, in cycles
//   - idx_to_onehot : converts a 2-bit owner index to a 4-bit one-hot grant
// -----------------------------------------------------------------------------
package bus_arb_4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    localparam int unsigned MAX_HOLD_DEFAULT = 16;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_arb_4_rr_pick_4.sv
// -----------------------------------------------------------------------------
// rr_pick_4
// Combinational round-robin picker for four requesters. The search starts at
// (last+1) mod 4 and walks upward with wrap; the first requester found wins.
// Ports:
//   req   [3:0] in  : request vector, bit i = requester i
//   last  [1:0] in  : index of the most recent winner (lowest priority now)
//   valid       out : at least one request present
//   idx   [1:0] out : winning requester index (equals last when valid=0)
// -----------------------------------------------------------------------------
module rr_pick_4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    // cand[k] is the requester examined at search position k; rot[k] is its
    // request bit, so rot is req rotated to put the highest priority at 0.
    logic [1:0] cand [4];
    logic [3:0] rot;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign cand[gi] = 2'(last + 2'(gi + 1));
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |rot;
        idx   = last;
        // Walk from lowest to highest priority so the highest one present
        // is the last assignment and wins.
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/bus_arb_4.sv
// -----------------------------------------------------------------------------
// bus_arb_4
// Round-robin arbiter for a shared 16-bit bus with four requesters. The owner
// holds the bus until it pulses done, drops its request, or reaches MAX_HOLD
// cycles (forced release, flagged by timeout). Every release is followed by a
// one-cycle TURN state for bus turnaround before the next arbitration in IDLE.
// Parameters:
//   MAX_HOLD : maximum hold time in cycles (legal 2..255)
// Ports:
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset
//   req    [3:0] in  : level requests, bit i = requester i (mux leg A..D)
//   done   [3:0] in  : release pulses; only the current owner's bit matters
//   grant  [3:0] out : registered one-hot ownership, zero when no owner
//   sel    [1:0] out : registered select for the external 4:1 bus mux
//   busy         out : registered, high while a grant bit is high
//   timeout      out : registered one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module bus_arb_4
    import bus_arb_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    arb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic       pick_valid;
    logic [1:0] pick_idx;

    logic       owner_done;
    logic       owner_req;
    logic       at_limit;

    rr_pick_4 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // sel_q is the owner index whenever the FSM is in OWN.
    assign owner_done = done[sel_q];
    assign owner_req  = req[sel_q];
    assign at_limit   = (cnt_q == HOLD_LIMIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    cnt_d   = 8'd0;
                    grant_d = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    last_d  = pick_idx;
                end else begin
                    // sel keeps its value so the bus mux does not toggle.
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end

            OWN: begin
                if (owner_done || !owner_req || at_limit) begin
                    state_d   = TURN;
                    cnt_d     = 8'd0;
                    grant_d   = 4'b0000;
                    busy_d    = 1'b0;
                    // Only a release the owner did not ask for is a timeout.
                    timeout_d = at_limit && !owner_done && owner_req;
                end else begin
                    // Exit at HOLD_LIMIT keeps this from ever wrapping.
                    cnt_d = cnt_q + 8'd1;
                end
            end

            TURN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            last_q    <= 2'd3;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
